// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit
// Purpose  : Registered RV32 branch resolution stage. Evaluates the six
//            conditional branches plus JAL/JALR, computes the target and
//            fall-through address, checks the front-end prediction and emits
//            a redirect result over valid/ready. After a mispredict leaves
//            the stage, younger wrong-path beats are squashed until flush.
// Options  : BRU_PERF_CNT_EN - build saturating branch/mispredict counters
//            (otherwise perf_branches/perf_mispredicts are tied to 0).
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_jal,
  input  logic             in_jalr,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_imm,
  input  logic             in_pred_taken,
  input  logic [XLEN-1:0]  in_pred_target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic [XLEN-1:0]  out_target,
  output logic             out_mispredict,
  output logic             out_misalign,
  output logic [CNT_W-1:0] perf_branches,
  output logic [CNT_W-1:0] perf_mispredicts
);

  // Branch condition encodings (RV32 funct3); 3'b010/3'b011 are undefined.
  localparam logic [2:0] c_BEQ  = 3'b000;
  localparam logic [2:0] c_BNE  = 3'b001;
  localparam logic [2:0] c_BLT  = 3'b100;
  localparam logic [2:0] c_BGE  = 3'b101;
  localparam logic [2:0] c_BLTU = 3'b110;
  localparam logic [2:0] c_BGEU = 3'b111;

  localparam logic [XLEN-1:0] c_FOUR = XLEN'(4);

  typedef enum logic [0:0] {
    S_RUN    = 1'b0,
    S_SQUASH = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic            r_out_valid;
  logic            r_taken;
  logic [XLEN-1:0] r_target;
  logic            r_mispredict;
  logic            r_misalign;

  logic            w_eq;
  logic            w_lt_s;
  logic            w_lt_u;
  logic            w_cond;
  logic            w_taken;
  logic [XLEN-1:0] w_pc_imm;
  logic [XLEN-1:0] w_rs1_imm;
  logic [XLEN-1:0] w_jump_tgt;
  logic [XLEN-1:0] w_pc4;
  logic [XLEN-1:0] w_result_tgt;
  logic            w_mispredict;
  logic            w_misalign;
  logic            w_out_valid;
  logic            w_xfer;
  logic            w_in_ready;
  logic            w_load;

  // Operand comparisons and address arithmetic (all modulo 2^XLEN).
  assign w_eq       = (in_rs1 == in_rs2);
  assign w_lt_s     = ($signed(in_rs1) < $signed(in_rs2));
  assign w_lt_u     = (in_rs1 < in_rs2);
  assign w_pc_imm   = in_pc + in_imm;
  assign w_rs1_imm  = in_rs1 + in_imm;
  assign w_pc4      = in_pc + c_FOUR;
  // JALR takes priority over JAL and always clears bit 0 of its target.
  assign w_jump_tgt = in_jalr ? {w_rs1_imm[XLEN-1:1], 1'b0} : w_pc_imm;

  // Conditional branch evaluation; undefined encodings resolve not-taken.
  always_comb begin
    w_cond = 1'b0;
    case (in_op)
      c_BEQ:   w_cond = w_eq;
      c_BNE:   w_cond = !w_eq;
      c_BLT:   w_cond = w_lt_s;
      c_BGE:   w_cond = !w_lt_s;
      c_BLTU:  w_cond = w_lt_u;
      c_BGEU:  w_cond = !w_lt_u;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_taken      = in_jal || in_jalr || w_cond;
  assign w_result_tgt = w_taken ? w_jump_tgt : w_pc4;
  // A correctly predicted not-taken beat never redirects, whatever the
  // predicted target says.
  assign w_mispredict = (w_taken != in_pred_taken) ||
                        (w_taken && (w_jump_tgt != in_pred_target));
  assign w_misalign   = w_taken && (w_jump_tgt[1:0] != 2'b00);

  // The output register may hold a wrong-path beat loaded on the same edge
  // the mispredict left; it stays hidden while squashing and flush drops it.
  assign w_out_valid = r_out_valid && (r_state == S_RUN);
  assign w_xfer      = w_out_valid && out_ready;

  // Next-state, input acceptance and load decision.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_load      = 1'b0;
    if (rst) begin
      w_state_nxt = S_RUN;
    end else if (flush) begin
      w_state_nxt = S_RUN;
    end else begin
      case (r_state)
        S_RUN: begin
          w_in_ready = !w_out_valid || out_ready;
          w_load     = in_valid && w_in_ready;
          if (w_xfer && r_mispredict) begin
            w_state_nxt = S_SQUASH;
          end
        end
        S_SQUASH: begin
          w_in_ready = 1'b1;
        end
        default: begin
          w_state_nxt = S_RUN;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output register: reload on accept, clear on drain or flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_taken      <= 1'b0;
      r_target     <= '0;
      r_mispredict <= 1'b0;
      r_misalign   <= 1'b0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
    end else if (w_load) begin
      r_out_valid  <= 1'b1;
      r_taken      <= w_taken;
      r_target     <= w_result_tgt;
      r_mispredict <= w_mispredict;
      r_misalign   <= w_misalign;
    end else if (w_xfer) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign in_ready       = w_in_ready;
  assign out_valid      = w_out_valid;
  assign out_taken      = r_taken;
  assign out_target     = r_target;
  assign out_mispredict = r_mispredict;
  assign out_misalign   = r_misalign;

`ifdef BRU_PERF_CNT_EN
  logic [CNT_W-1:0] r_perf_br;
  logic [CNT_W-1:0] r_perf_mis;

  // Saturating counters of delivered results and delivered mispredicts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_br  <= '0;
      r_perf_mis <= '0;
    end else if (!flush && w_xfer) begin
      if (r_perf_br != {CNT_W{1'b1}}) begin
        r_perf_br <= r_perf_br + 1'b1;
      end
      if (r_mispredict && (r_perf_mis != {CNT_W{1'b1}})) begin
        r_perf_mis <= r_perf_mis + 1'b1;
      end
    end
  end

  assign perf_branches    = r_perf_br;
  assign perf_mispredicts = r_perf_mis;
`else
  assign perf_branches    = '0;
  assign perf_mispredicts = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolve_unit
// Purpose  : Self-checking bench for branch_resolve_unit: a table of hand
//            computed vectors plus sequences for squash, backpressure,
//            throughput and counter saturation, checked through a scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  typedef struct {
    logic [2:0]  op;
    logic        jal;
    logic        jalr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        pt;
    logic [31:0] ptg;
  } beat_t;

  typedef struct {
    logic        taken;
    logic [31:0] target;
    logic        mis;
    logic        mal;
  } res_t;

  typedef struct {
    beat_t b;
    res_t  r;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready, in_jal, in_jalr;
  logic [2:0]       in_op;
  logic [XLEN-1:0]  in_rs1, in_rs2, in_pc, in_imm, in_pred_target;
  logic             in_pred_taken;
  logic             out_valid, out_ready, out_taken, out_mispredict, out_misalign;
  logic [XLEN-1:0]  out_target;
  logic [CNT_W-1:0] perf_branches, perf_mispredicts;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_jal(in_jal), .in_jalr(in_jalr),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc), .in_imm(in_imm),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_taken(out_taken), .out_target(out_target),
    .out_mispredict(out_mispredict), .out_misalign(out_misalign),
    .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
  );

  int    n_vec = 0;
  int    n_err = 0;
  int    n_out = 0;
  int    cnt_br = 0;
  int    cnt_mis = 0;
  logic  m_valid = 1'b0;
  logic  m_squash = 1'b0;
  res_t  cur_exp;
  res_t  q[$];
  string tag = "reset";
  vec_t  tbl[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s.%s: got %h expected %h (t=%0t)", tag, nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s.%s: bound expired (t=%0t)", tag, nm, $time);
  endtask

  function automatic beat_t mk(input logic [2:0] op, input logic jal, input logic jalr,
                               input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic [31:0] pc, input logic [31:0] imm,
                               input logic pt, input logic [31:0] ptg);
    beat_t b;
    b.op = op; b.jal = jal; b.jalr = jalr; b.rs1 = rs1; b.rs2 = rs2;
    b.pc = pc; b.imm = imm; b.pt = pt; b.ptg = ptg;
    return b;
  endfunction

  function automatic res_t mr(input logic t, input logic [31:0] tg, input logic m, input logic a);
    res_t r;
    r.taken = t; r.target = tg; r.mis = m; r.mal = a;
    return r;
  endfunction

  // Reference behaviour written from the instruction semantics.
  function automatic res_t ref_model(input beat_t b);
    res_t        r;
    logic        tk;
    logic [31:0] tg;
    case (b.op)
      3'd0:    tk = (b.rs1 == b.rs2);
      3'd1:    tk = (b.rs1 != b.rs2);
      3'd4:    tk = ($signed(b.rs1) < $signed(b.rs2));
      3'd5:    tk = ($signed(b.rs1) >= $signed(b.rs2));
      3'd6:    tk = (b.rs1 < b.rs2);
      3'd7:    tk = (b.rs1 >= b.rs2);
      default: tk = 1'b0;
    endcase
    tg = b.pc + b.imm;
    if (b.jalr) begin
      tk = 1'b1;
      tg = (b.rs1 + b.imm) & 32'hFFFF_FFFE;
    end else if (b.jal) begin
      tk = 1'b1;
    end
    r.taken  = tk;
    r.target = tk ? tg : (b.pc + 32'd4);
    r.mis    = (tk != b.pt) || (tk && (tg != b.ptg));
    r.mal    = tk && (tg[1:0] != 2'b00);
    return r;
  endfunction

  task automatic drive(input beat_t b, input res_t e);
    in_valid = 1'b1; in_op = b.op; in_jal = b.jal; in_jalr = b.jalr;
    in_rs1 = b.rs1; in_rs2 = b.rs2; in_pc = b.pc; in_imm = b.imm;
    in_pred_taken = b.pt; in_pred_target = b.ptg;
    cur_exp = e;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Mid-cycle check of the DUT against the scoreboard, then model update for
  // the coming rising edge.
  task automatic eval();
    logic vis, exp_rdy, xf, mis_x;
    res_t h;
    vis     = m_valid && !m_squash;
    exp_rdy = !flush && (m_squash || !vis || out_ready);
    chk("out_valid", 32'(out_valid), 32'(vis));
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (vis && q.size() > 0) begin
      chk("taken", 32'(out_taken), 32'(q[0].taken));
      chk("target", out_target, q[0].target);
      chk("mispredict", 32'(out_mispredict), 32'(q[0].mis));
      chk("misalign", 32'(out_misalign), 32'(q[0].mal));
    end else if (vis) begin
      fail_now("scoreboard_empty");
    end
    if (flush) begin
      q.delete();
      m_valid  = 1'b0;
      m_squash = 1'b0;
    end else begin
      xf    = vis && out_ready;
      mis_x = 1'b0;
      if (xf && q.size() > 0) begin
        h = q.pop_front();
        n_out++;
        if (cnt_br < 15) cnt_br++;
        if (h.mis && cnt_mis < 15) cnt_mis++;
        mis_x   = h.mis;
        m_valid = 1'b0;
      end
      if (in_valid && exp_rdy && !m_squash) begin
        q.push_back(cur_exp);
        m_valid = 1'b1;
      end
      if (mis_x) m_squash = 1'b1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    eval();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 20; i++) begin
      if (!(m_valid && !m_squash)) break;
      tick();
    end
    if (m_valid && !m_squash) fail_now("drain_timeout");
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic chk_perf();
`ifdef BRU_PERF_CNT_EN
    chk("perf_branches", 32'(perf_branches), 32'(cnt_br));
    chk("perf_mispredicts", 32'(perf_mispredicts), 32'(cnt_mis));
`else
    chk("perf_branches", 32'(perf_branches), 32'd0);
    chk("perf_mispredicts", 32'(perf_mispredicts), 32'd0);
`endif
  endtask

  function automatic beat_t rand_beat(input logic want_mis);
    beat_t b;
    res_t  r;
    b = mk(3'($urandom_range(0, 7)), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 5) == 0), $urandom, $urandom, $urandom, $urandom,
           1'b0, $urandom);
    if ($urandom_range(0, 1) == 1) b.rs2 = b.rs1;
    r = ref_model(b);
    b.pt  = want_mis ? !r.taken : r.taken;
    b.ptg = r.taken ? ((b.jalr ? ((b.rs1 + b.imm) & 32'hFFFF_FFFE) : (b.pc + b.imm))) : $urandom;
    return b;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t b1, b2, b3, bb;
    int    n0;

    // Hand-computed vectors: op jal jalr rs1 rs2 pc imm pt ptg -> taken target mis mal
    tbl[0]  = '{mk(3'd4, 0, 0, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1, 32'h120), mr(1, 32'h120, 0, 0)};
    tbl[1]  = '{mk(3'd6, 0, 0, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1, 32'h120), mr(0, 32'h104, 1, 0)};
    tbl[2]  = '{mk(3'd0, 0, 1, 32'h2003, 32'h0, 32'h200, 32'h0, 1, 32'h2002), mr(1, 32'h2002, 0, 1)};
    tbl[3]  = '{mk(3'd1, 0, 0, 32'h1, 32'h2, 32'hFFFF_FFFC, 32'h8, 1, 32'h4), mr(1, 32'h4, 0, 0)};
    tbl[4]  = '{mk(3'd1, 0, 0, 32'h5, 32'h5, 32'hFFFF_FFFC, 32'h8, 0, 32'h1234), mr(0, 32'h0, 0, 0)};
    tbl[5]  = '{mk(3'd0, 0, 0, 32'h7, 32'h7, 32'h1000, 32'hFFFF_FFF0, 1, 32'hFF0), mr(1, 32'hFF0, 0, 0)};
    tbl[6]  = '{mk(3'd5, 0, 0, 32'h8000_0000, 32'h0, 32'h40, 32'h10, 0, 32'h0), mr(0, 32'h44, 0, 0)};
    tbl[7]  = '{mk(3'd7, 0, 0, 32'h8000_0000, 32'h0, 32'h40, 32'h10, 0, 32'h0), mr(1, 32'h50, 1, 0)};
    tbl[8]  = '{mk(3'd0, 1, 0, 32'h1, 32'h2, 32'h300, 32'h102, 1, 32'h402), mr(1, 32'h402, 0, 1)};
    tbl[9]  = '{mk(3'd0, 1, 1, 32'h1000, 32'h0, 32'h500, 32'h11, 1, 32'h802), mr(1, 32'h1010, 1, 0)};
    tbl[10] = '{mk(3'd2, 0, 0, 32'h0, 32'h0, 32'h600, 32'h40, 0, 32'h0), mr(0, 32'h604, 0, 0)};
    tbl[11] = '{mk(3'd0, 0, 0, 32'h3, 32'h3, 32'h700, 32'h8, 1, 32'h70C), mr(1, 32'h708, 1, 0)};
    tbl[12] = '{mk(3'd0, 0, 1, 32'h4, 32'h0, 32'h800, 32'hFFFF_FFF9, 0, 32'h0), mr(1, 32'hFFFF_FFFC, 1, 0)};

    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    idle();
    in_op = 3'd0; in_jal = 1'b0; in_jalr = 1'b0; in_rs1 = '0; in_rs2 = '0;
    in_pc = '0; in_imm = '0; in_pred_taken = 1'b0; in_pred_target = '0;
    cur_exp = mr(0, 0, 0, 0);

    // Reset state, with a beat offered that must not be accepted.
    repeat (2) @(posedge clk);
    drive(tbl[0].b, tbl[0].r);
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'd0);
    chk("out_valid", 32'(out_valid), 32'd0);
    chk("taken", 32'(out_taken), 32'd0);
    chk("target", out_target, 32'd0);
    chk("mispredict", 32'(out_mispredict), 32'd0);
    chk("misalign", 32'(out_misalign), 32'd0);
    chk_perf();
    @(posedge clk); #1;
    idle();
    rst = 1'b0;
    tick();

    // Table vectors, one at a time; redirecting results are followed by flush.
    for (int i = 0; i < 13; i++) begin
      tag = $sformatf("tbl%0d", i);
      out_ready = 1'b1;
      drive(tbl[i].b, tbl[i].r);
      tick();
      drain();
      if (tbl[i].r.mis) pulse_flush();
    end
    tag = "tbl_perf";
    chk_perf();

    // Squash: beats after a mispredict are swallowed until flush.
    tag = "squash";
    b1 = tbl[1].b;
    b2 = mk(3'd0, 0, 0, 32'h9, 32'h9, 32'h900, 32'h10, 1, 32'h910);
    b3 = mk(3'd1, 0, 0, 32'h9, 32'h9, 32'hA00, 32'h10, 0, 32'h0);
    n0 = n_out;
    drive(b1, ref_model(b1)); tick();
    drive(b2, ref_model(b2)); tick();
    drive(b3, ref_model(b3)); tick();
    drive(b2, ref_model(b2)); tick();
    idle(); tick(); tick();
    drive(b2, ref_model(b2));
    pulse_flush();
    drive(b3, ref_model(b3)); tick();
    drain();
    chk("beats_out", 32'(n_out - n0), 32'd2);

    // Backpressure: held beat stays stable, next beat waits, none lost.
    tag = "stall";
    n0 = n_out;
    out_ready = 1'b0;
    drive(b2, ref_model(b2)); tick();
    drive(b3, ref_model(b3));
    repeat (3) tick();
    out_ready = 1'b1;
    tick();
    drain();
    chk("beats_out", 32'(n_out - n0), 32'd2);

    // Flush during a stall drops the held result.
    tag = "stall_flush";
    n0 = n_out;
    out_ready = 1'b0;
    drive(b2, ref_model(b2)); tick();
    drive(b3, ref_model(b3)); tick(); tick();
    pulse_flush();
    idle(); tick();
    out_ready = 1'b1;
    tick();
    chk("beats_out", 32'(n_out - n0), 32'd0);

    // Full throughput with correctly predicted random beats.
    tag = "stream";
    n0 = n_out;
    for (int i = 0; i < 8; i++) begin
      bb = rand_beat(1'b0);
      drive(bb, ref_model(bb));
      tick();
    end
    drain();
    chk("beats_out", 32'(n_out - n0), 32'd8);

    // Counter saturation: 20 beats, 17 of them mispredicted.
    tag = "perf";
    for (int i = 0; i < 20; i++) begin
      bb = rand_beat(i < 17);
      drive(bb, ref_model(bb));
      tick();
      drain();
      if (i < 17) pulse_flush();
    end
    chk_perf();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Registered, parametrised branch resolution stage for the RV32 core's execute pipeline. It evaluates the six conditional-branch conditions plus JAL/JALR, computes the branch target and fall-through address, compares the outcome with the front-end prediction, and emits a redirect/mispredict result over a valid/ready handshake. After a mispredict it squashes younger wrong-path instructions until the pipeline flush arrives.

## Interface
Parameters:
- XLEN, 32, datapath, PC and immediate width (≥ 8)
- CNT_W, 32, performance counter width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush; highest priority after rst
- in_valid  in  1  input beat valid
- in_ready  out  1  unit can accept a beat this cycle
- in_op  in  3  branch condition; encodings `BEQ`/`BNE`/`BLT`/`BGE`/`BLTU`/`BGEU` from defines.vh
- in_jal  in  1  unconditional jump; target pc+imm
- in_jalr  in  1  register jump; target (rs1+imm) with bit 0 cleared; wins over in_jal
- in_rs1, in_rs2  in  XLEN each  operands
- in_pc, in_imm  in  XLEN each  instruction PC, sign-extended immediate
- in_pred_taken  in  1  front-end prediction
- in_pred_target  in  XLEN  predicted target
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_taken  out  1  resolved direction
- out_target  out  XLEN  taken ? target : pc+4
- out_mispredict  out  1  redirect required
- out_misalign  out  1  taken and target[1:0] ≠ 0
- perf_branches  out  CNT_W  resolved-beat count
- perf_mispredicts  out  CNT_W  mispredict count

## Operation
- Condition: BEQ/BNE equality; BLT/BGE signed compare; BLTU/BGEU unsigned; undefined in_op → not taken. in_jal or in_jalr → taken regardless of in_op.
- Arithmetic: pc+imm, rs1+imm, pc+4 all modulo 2^XLEN; wrap-around silent, no overflow flag.
- Mispredict = (taken ≠ in_pred_taken) OR (taken AND target ≠ in_pred_target). Not-taken correctly predicted never mispredicts, regardless of in_pred_target.
- out_misalign reported only when taken; informative, does not suppress out_mispredict.
- FSM states: RUN, SQUASH.
  - RUN: in_ready = !out_valid || out_ready. Accepted beat loads the output register.
  - RUN→SQUASH: on an output transfer (out_valid & out_ready) with out_mispredict=1.
  - SQUASH: in_ready=1; accepted beats discarded (no output, not counted); out_valid=0.
  - SQUASH→RUN: on flush.
- flush (any state): out_valid←0, state←RUN, same-cycle input beat dropped, counters unaffected.
- rst: out_valid=0, out_taken=0, out_target=0, out_mispredict=0, out_misalign=0, state=RUN, counters=0. in_ready is 0 during rst and flush.

## Timing
- Latency 1 cycle: beat accepted at edge N appears on out_* after edge N.
- Full throughput: one beat per cycle while out_ready=1.
- Backpressure: out_valid=1 & out_ready=0 holds all out_* stable, in_ready=0.
- Simultaneous transfer-out and accept-in: register reloads same edge, out_valid stays 1.
- Mispredict result transferred at edge N: beat presented at edge N is still accepted and loaded (state RUN at N); SQUASH effective from N+1.
- out_* data don't-care when out_valid=0 except at reset.

## Configuration
- BRU_PERF_CNT_EN defined: perf_branches increments on each output transfer; perf_mispredicts also when out_mispredict=1; both saturate at 2^CNT_W−1; cleared only by rst.
- Undefined: counters not built, both ports tied to 0.

## Test plan
- BLT rs1=0xFFFF_FFFF, rs2=1, pc=0x100, imm=0x20, pred_taken=1, pred_target=0x120 → taken=1, target=0x120, mispredict=0, one cycle later.
- BLTU same operands, pred_taken=1 → taken=0, target=0x104, mispredict=1; next two beats during SQUASH produce no output until flush, then normal resumption.
- JALR rs1=0x2003, imm=0 → target=0x2002, misalign=1, taken=1.
- pc=0xFFFF_FFFC, BNE not equal, imm=8 → target=0x4 (wrap); not taken case gives target=0x0.
- out_ready low 3 cycles with in_valid high → out_* stable, in_ready=0, no beats lost or duplicated; flush mid-stall clears out_valid.
- With BRU_PERF_CNT_EN, CNT_W=4: 20 beats, 17 mispredicts (flush between each) → both counters saturate at 15; without macro both read 0.
